serial_compare_frame_sequencer: RTL
===================================

# serial_compare_frame_sequencer

Sits directly upstream of the MSB-first FSM serial comparator and closes the loop around it. It accepts two parallel WIDTH-bit operands over a valid/ready handshake and issues a one-cycle frame clear to the comparator. It then shifts both operands out MSB-first, one bit pair per cycle, samples the comparator's flags on the last bit and returns the result as a registered, one-cycle-valid word.

## Interface
- WIDTH, default 8, operand width in bits; legal range ≥ 1.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  WIDTH  operand A (parallel).
- in_b  input  WIDTH  operand B (parallel).
- frame_rst  output  1  one-cycle clear to the comparator; the integrator drives the comparator's rst with rst OR frame_rst.
- a  output  1  serial bit of A, MSB first; 0 when bit_valid = 0.
- b  output  1  serial bit of B, MSB first; 0 when bit_valid = 0.
- bit_valid  output  1  a/b carry a live bit this cycle.
- last  output  1  current bit is the LSB; only ever high together with bit_valid.
- cmp_less  input  1  comparator a_less_b, its combinational output for the current bit.
- cmp_eq  input  1  comparator a_eq_b.
- cmp_greater  input  1  comparator a_greater_b.
- res_valid  output  1  one-cycle pulse; res_* hold a new result.
- res_less  output  1  captured A < B.
- res_eq  output  1  captured A = B.
- res_greater  output  1  captured A > B.

## Operation
- States:
  - IDLE: in_ready = 1.
  - CLEAR: frame_rst = 1.
  - SHIFT: bit_valid = 1.
- IDLE → CLEAR on in_valid & in_ready.
  - Latch in_a and in_b into shift registers sh_a and sh_b.
  - Load the bit counter with WIDTH-1.
- CLEAR → SHIFT unconditionally, after exactly one cycle.
- In SHIFT:
  - a = sh_a[WIDTH-1] and b = sh_b[WIDTH-1].
  - Both registers shift left by 1 each cycle, zero-filled.
  - The counter decrements each cycle; last = (count == 0).
- SHIFT with last → IDLE.
  - On that edge, res_less/res_eq/res_greater load cmp_less/cmp_eq/cmp_greater.
  - res_valid is set for exactly the following cycle.
- res_* hold their value until the next capture; res_valid is a pulse only.
- in_valid is ignored outside IDLE.
- in_a and in_b need only be stable in the acceptance cycle.
- Counter width is max(1, $clog2(WIDTH)).
- The comparator input is never checked for one-hot; it is captured verbatim.

## Timing
- Reset (async assert, release synchronous to clk):
  - State → IDLE.
  - sh_a, sh_b, counter, res_* and res_valid = 0.
  - While rst is high, in_ready, frame_rst, bit_valid, last, a and b are all 0.
- Frame timeline, with the acceptance edge at the end of cycle 0:
  - Cycle 1: frame_rst.
  - Cycles 2..WIDTH+1: bits, MSB first.
  - Cycle WIDTH+1: last.
  - Cycle WIDTH+2: res_valid, with in_ready = 1 again.
- Throughput is one frame per WIDTH+2 cycles.
  - A new pair may be accepted in the res_valid cycle.
  - Back-to-back frames therefore have no extra bubble.
- The comparator's flags sampled on the last edge reflect all WIDTH bits, because its outputs are combinational from the current bit.
- Reset mid-frame (CLEAR or SHIFT):
  - The frame is aborted immediately.
  - No res_valid is issued.
  - res_* are cleared to 0.
- WIDTH = 1: the CLEAR cycle is followed by a single SHIFT cycle with last = 1.

## Test plan
- WIDTH=8, in_a=0xA5, in_b=0xA5, single accept:
  - frame_rst in cycle 1.
  - a = b = 1,0,1,0,0,1,0,1 over cycles 2..9.
  - last only in cycle 9.
  - res_valid in cycle 10 with res_eq=1, res_less=0, res_greater=0.
- in_a=0x80, in_b=0x7F:
  - The first bit pair (1,0) decides.
  - res_greater=1 after 8 bits; the later bits are ignored.
- in_a=0x12, in_b=0x13:
  - Only the LSB differs.
  - res_less=1, res_eq=0.
- in_valid held high with pairs (0x01,0x02) then (0x03,0x03):
  - The second pair is accepted in the first frame's res_valid cycle.
  - in_ready=0 throughout both frames.
  - Results are less, then equal; res_valid pulses exactly 10 cycles apart.
- Assert rst after 4 bits of a frame:
  - All outputs go to 0 at once and no res_valid appears.
  - After release, a frame with (0xFF,0x00) yields res_greater=1.
- WIDTH=1 with (1,0), (0,1) and (1,1):
  - Each frame takes 3 cycles.
  - Results are greater, less and equal respectively.

Source files
------------

// File: rtl/serial_compare_frame_sequencer.sv
// Feeds an MSB-first serial comparator: accepts an operand pair, clears the comparator,
// shifts both operands out one bit pair per cycle and captures the comparator flags on the LSB.
module serial_compare_frame_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             frame_rst,
   output logic             a,
   output logic             b,
   output logic             bit_valid,
   output logic             last,
   input  logic             cmp_less,
   input  logic             cmp_eq,
   input  logic             cmp_greater,
   output logic             res_valid,
   output logic             res_less,
   output logic             res_eq,
   output logic             res_greater
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sh_a_reg, sh_b_reg;
   logic [CW-1:0]    count_reg;
   logic             accept;
   logic             shift_last;

   assign accept     = in_valid && in_ready;
   assign shift_last = (state_reg == SHIFT) && (count_reg == '0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = CLEAR;
         CLEAR:   state_next = SHIFT;
         SHIFT:   if (shift_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are forced low while reset is held, even though the state is already IDLE
   always_comb begin
      in_ready  = 1'b0;
      frame_rst = 1'b0;
      bit_valid = 1'b0;
      last      = 1'b0;
      a         = 1'b0;
      b         = 1'b0;
      if (!rst) begin
         case (state_reg)
            IDLE:  in_ready = 1'b1;
            CLEAR: frame_rst = 1'b1;
            SHIFT: begin
               bit_valid = 1'b1;
               last      = (count_reg == '0);
               a         = sh_a_reg[WIDTH-1];
               b         = sh_b_reg[WIDTH-1];
            end
            default: ;
         endcase
      end
   end

   // Shift registers and bit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_a_reg  <= '0;
         sh_b_reg  <= '0;
         count_reg <= '0;
      end else if (accept) begin
         sh_a_reg  <= in_a;
         sh_b_reg  <= in_b;
         count_reg <= CW'(WIDTH - 1);
      end else if (state_reg == SHIFT) begin
         sh_a_reg  <= sh_a_reg << 1;
         sh_b_reg  <= sh_b_reg << 1;
         count_reg <= count_reg - 1'b1;
      end
   end

   // Flags are taken verbatim on the LSB edge; the comparator is combinational from the current bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid   <= 1'b0;
         res_less    <= 1'b0;
         res_eq      <= 1'b0;
         res_greater <= 1'b0;
      end else begin
         res_valid <= shift_last;
         if (shift_last) begin
            res_less    <= cmp_less;
            res_eq      <= cmp_eq;
            res_greater <= cmp_greater;
         end
      end
   end

endmodule
